// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: queues vend/change events from the vending FSM and
// drives the product motor and nickel hopper with fixed mechanical timing.
//
// state    | meaning
// IDLE     | waiting; pops the queue head when non-empty
// MOTOR    | product motor on for MOTOR_CYCLES
// COIN_ON  | hopper solenoid on for COIN_ON_CYCLES
// COIN_OFF | gap after a coin for COIN_GAP_CYCLES
// DONE     | one-cycle completion pulse
module vend_dispense_ctrl #(
  parameter int DEPTH           = 4,
  parameter int MOTOR_CYCLES    = 8,
  parameter int COIN_ON_CYCLES  = 4,
  parameter int COIN_GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       R,
  input  logic       vend_in,
  input  logic [1:0] ch_in,
  output logic       motor,
  output logic       coin_eject,
  output logic       done,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = 16;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] MOTOR_T  = TW'(MOTOR_CYCLES - 1);
  localparam logic [TW-1:0] CON_T    = TW'(COIN_ON_CYCLES - 1);
  localparam logic [TW-1:0] COFF_T   = TW'(COIN_GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MOTOR    = 3'd1;
  localparam logic [2:0] S_COIN_ON  = 3'd2;
  localparam logic [2:0] S_COIN_OFF = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]    q_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ovf_r;
  logic [2:0]    state;
  logic [TW-1:0] tmr;
  logic [1:0]    coins_r;
  logic          push_req, push_ok, pop;
  logic [2:0]    head;

  assign push_req = vend_in | (ch_in != 2'b00);
  assign pop      = (state == S_IDLE) && (count != '0);
  // A full queue still accepts when the sequencer frees a slot on the same edge.
  assign push_ok  = push_req && ((count != FULL_CNT) || pop);
  assign head     = q_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!R && push_ok) q_mem[wr_ptr] <= {vend_in, ch_in};
  end

  always_ff @(posedge clk) begin
    if (R) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) ovf_r <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state   <= S_IDLE;
      tmr     <= '0;
      coins_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            coins_r <= head[1:0];
            if (head[2]) begin
              state <= S_MOTOR;
              tmr   <= MOTOR_T;
            end else begin
              state <= S_COIN_ON;
              tmr   <= CON_T;
            end
          end
        end
        S_MOTOR: begin
          if (tmr == '0) begin
            if (coins_r != 2'd0) begin
              state <= S_COIN_ON;
              tmr   <= CON_T;
            end else begin
              state <= S_DONE;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_COIN_ON: begin
          if (tmr == '0) begin
            state   <= S_COIN_OFF;
            tmr     <= COFF_T;
            coins_r <= coins_r - 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_COIN_OFF: begin
          if (tmr == '0) begin
            if (coins_r != 2'd0) begin
              state <= S_COIN_ON;
              tmr   <= CON_T;
            end else begin
              state <= S_DONE;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign motor      = (state == S_MOTOR);
  assign coin_eject = (state == S_COIN_ON);
  assign done       = (state == S_DONE);
  assign busy       = (state != S_IDLE) || (count != '0);
  assign full       = (count == FULL_CNT);
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scoreboard bench for vend_dispense_ctrl: an event-level timing model predicts
// each accepted event's start cycle and waveform; a monitor checks DUT outputs.
module tb_vend_dispense_ctrl;
  localparam int DEPTH = 4;
  localparam int MC    = 8;
  localparam int CON   = 4;
  localparam int COFF  = 4;
  localparam int NEVER = 1 << 30;

  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic       vend_in = 1'b0;
  logic [1:0] ch_in = 2'b00;
  logic       motor, coin_eject, done, busy, full, overflow;

  vend_dispense_ctrl #(.DEPTH(DEPTH), .MOTOR_CYCLES(MC),
                       .COIN_ON_CYCLES(CON), .COIN_GAP_CYCLES(COFF)) dut (
    .clk(clk), .R(R), .vend_in(vend_in), .ch_in(ch_in),
    .motor(motor), .coin_eject(coin_eject), .done(done),
    .busy(busy), .full(full), .overflow(overflow));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cap; int start; int done_c;} acc_t;
  typedef struct {int start; bit v; int coins;} exp_t;
  acc_t acc[$];
  exp_t expq[$];
  int last_done = -100;
  int ovf_edge  = NEVER;
  int total = 0, bad = 0;
  int motor_rises = 0, coin_rises = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ev_len(input bit v, input int coins);
    return (v ? MC : 0) + coins * (CON + COFF) + 1;
  endfunction

  // Event server model: one event at a time, FIFO order, DEPTH waiting slots.
  task automatic model_capture(input int c, input bit v, input int coins);
    int  cnt = 0;
    bit  popnow = 0;
    int  s;
    foreach (acc[i]) begin
      if (acc[i].cap <= c - 1 && acc[i].start >= c) cnt++;
      if (acc[i].start == c) popnow = 1;
    end
    if (cnt < DEPTH || popnow) begin
      s = (c + 1 > last_done + 2) ? c + 1 : last_done + 2;
      last_done = s + ev_len(v, coins) - 1;
      acc.push_back('{cap: c, start: s, done_c: last_done});
      expq.push_back('{start: s, v: v, coins: coins});
    end else if (ovf_edge > c) begin
      ovf_edge = c;
    end
  endtask

  task automatic step(input bit v, input logic [1:0] ch);
    vend_in = v;
    ch_in   = ch;
    if (v || ch != 2'b00) model_capture(cyc + 1, v, int'(ch));
    @(posedge clk); #1;
    vend_in = 1'b0;
    ch_in   = 2'b00;
  endtask

  task automatic do_reset();
    R = 1'b1;
    @(posedge clk); #1;
    acc.delete();
    expq.delete();
    last_done = -100;
    ovf_edge  = NEVER;
    @(posedge clk); #1;
    R = 1'b0;
    chk("post_reset_outputs", {motor, coin_eject, done, busy, full, overflow}, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      step(1'b0, 2'b00);
      n++;
    end
    chk("drain_busy", int'(busy), 0);
  endtask

  function automatic int wave(input exp_t e, input int t);
    int u;
    if (e.v && t < MC) return 3'b100;
    u = t - (e.v ? MC : 0);
    if (u < e.coins * (CON + COFF)) return ((u % (CON + COFF)) < CON) ? 3'b010 : 3'b000;
    return 3'b001;
  endfunction

  // Monitor: per-cycle status check plus per-event waveform scoreboard.
  exp_t cur;
  bit   in_ev = 1'b0;
  int   t_ev = 0, dur = 0;
  logic pm = 1'b0, pc = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      int cnt_e;
      bit busy_e;
      cnt_e  = 0;
      busy_e = 0;
      foreach (acc[i]) begin
        if (acc[i].cap <= cyc && acc[i].done_c >= cyc) busy_e = 1;
        if (acc[i].cap <= cyc && acc[i].start > cyc) cnt_e++;
      end
      chk("status_busy_full_ovf", {busy, full, overflow},
          {busy_e, cnt_e == DEPTH, ovf_edge <= cyc});
      if (motor && !pm) motor_rises++;
      if (coin_eject && !pc) coin_rises++;
      pm = motor;
      pc = coin_eject;
      if (!in_ev && (motor || coin_eject || done)) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got m/c/d=%b%b%b expected 000 (cycle %0d)",
                   motor, coin_eject, done, cyc);
        end else begin
          cur   = expq.pop_front();
          in_ev = 1'b1;
          t_ev  = 0;
          dur   = ev_len(cur.v, cur.coins);
          chk("event_start_cycle", cyc, cur.start);
        end
      end
      if (in_ev) begin
        chk("event_waveform", {motor, coin_eject, done}, wave(cur, t_ev));
        t_ev++;
        if (t_ev == dur) in_ev = 1'b0;
      end
      if (R) in_ev = 1'b0;
    end
  end

  initial begin
    int m0, c0, n;
    int r;
    repeat (3) @(posedge clk);
    #1;
    R = 1'b0;
    mon_en = 1'b1;

    repeat (20) step(1'b0, 2'b00);
    chk("idle_busy", int'(busy), 0);

    m0 = motor_rises; c0 = coin_rises;
    step(1'b1, 2'b00);
    drain();
    chk("single_vend_motor", motor_rises - m0, 1);
    chk("single_vend_coins", coin_rises - c0, 0);

    m0 = motor_rises; c0 = coin_rises;
    step(1'b0, 2'b10);
    drain();
    chk("cancel_motor", motor_rises - m0, 0);
    chk("cancel_coins", coin_rises - c0, 2);

    m0 = motor_rises; c0 = coin_rises;
    step(1'b1, 2'b01);
    drain();
    chk("vend_change_motor", motor_rises - m0, 1);
    chk("vend_change_coins", coin_rises - c0, 1);

    m0 = motor_rises;
    repeat (6) step(1'b1, 2'b00);
    chk("six_full", int'(full), 1);
    chk("six_overflow", int'(overflow), 1);
    drain();
    chk("six_bursts", motor_rises - m0, 5);
    chk("overflow_sticky", int'(overflow), 1);

    do_reset();
    c0 = coin_rises;
    step(1'b0, 2'b10);
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    n = 0;
    while (coin_rises < c0 + 2 && n < 100) begin
      step(1'b0, 2'b00);
      n++;
    end
    chk("second_coin_seen", coin_rises - c0, 2);
    do_reset();
    m0 = motor_rises; c0 = coin_rises;
    repeat (40) step(1'b0, 2'b00);
    chk("post_reset_no_motor", motor_rises - m0, 0);
    chk("post_reset_no_coin", coin_rises - c0, 0);

    do_reset();
    repeat (400) begin
      r = $urandom_range(0, 9);
      if (r < 3) step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      else step(1'b0, 2'b00);
    end
    drain();
    repeat (3) step(1'b0, 2'b00);
    chk("scoreboard_empty", expq.size(), 0);
    chk("monitor_idle", int'(in_ev), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
- Downstream of the coin-accepting vending FSM; consumes its registered outputs: the vend pulse (`out`) and the change code (`ch`).
- Queues each vend/change event.
- Sequences the physical actuators: a product motor pulse, then one eject pulse per 5-unit coin of change, from a nickel-only hopper.
- Decouples one-cycle FSM events from multi-cycle mechanical timing.

Parameters:
- DEPTH, 4: event queue entries; power of two, at least 2.
- MOTOR_CYCLES, 8: cycles `motor` is held high per vend; at least 1.
- COIN_ON_CYCLES, 4: cycles `coin_eject` is high per coin; at least 1.
- COIN_GAP_CYCLES, 4: low cycles after each coin pulse; at least 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- R  in  1  reset; synchronous, active-high.
- vend_in  in  1  vend request from the FSM's `out`.
- ch_in  in  2  change code from the FSM's `ch`; value = number of 5-unit coins to return (01=1, 10=2, 11=3).
- motor  out  1  product motor drive.
- coin_eject  out  1  hopper solenoid drive, one pulse per coin.
- done  out  1  one-cycle pulse when an event finishes.
- busy  out  1  high if the queue is non-empty or the sequencer is not in IDLE.
- full  out  1  queue holds DEPTH entries.
- overflow  out  1  sticky; an event was dropped.

Behaviour:
- Clock and reset: single clock `clk`; reset `R` is synchronous and active-high.
- Reset values: all outputs 0; queue empty; pointers and counters 0; state IDLE. Reset mid-sequence aborts immediately and discards queued events.
- Capture: an event is any cycle where `vend_in`=1 or `ch_in`!=00. Each such sampled cycle pushes one 3-bit entry {vend, ch}. Cycles with vend=0 and ch=00 push nothing.
- Push acceptance: a push is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and `overflow` is set; it stays set until R.
- Queue: FIFO ordering; pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1. `full` = (count==DEPTH), registered.
- Sequencer states: IDLE, MOTOR, COIN_ON, COIN_OFF, DONE. Outputs are Moore-decoded from registered state:
  - `motor` = (state==MOTOR)
  - `coin_eject` = (state==COIN_ON)
  - `done` = (state==DONE)
- IDLE: if the queue is non-empty, pop the head into vend_r and coins_r at the edge, then:
  - vend_r=1 → MOTOR
  - otherwise → COIN_ON
- MOTOR: stays exactly MOTOR_CYCLES cycles. Then:
  - coins_r>0 → COIN_ON
  - otherwise → DONE
- COIN_ON: stays exactly COIN_ON_CYCLES cycles, then → COIN_OFF; coins_r decrements on exit.
- COIN_OFF: stays exactly COIN_GAP_CYCLES cycles. Then:
  - coins_r>0 → COIN_ON
  - otherwise → DONE
- DONE: one cycle, → IDLE. Back-to-back events are therefore separated by at least one DONE cycle plus one IDLE cycle.
- Latency: event sampled at edge c is in the queue in cycle c. It pops at edge c+1 if the sequencer is idle. First actuator output is high in cycle c+1.
- Pushes during a sequence are accepted normally; the sequencer never reads the queue outside IDLE.
- `busy` = (state!=IDLE) or (count!=0).

Test Plan:
- Reset hold then release, no events → all outputs 0 indefinitely; `busy`=0.
- Single vend (vend_in=1, ch_in=00, one cycle) → `motor` high exactly 8 cycles starting the cycle after capture; no `coin_eject`; `done` pulses once; then `busy`=0.
- Cancel with ch_in=10 only → 2 `coin_eject` pulses of 4 cycles each, separated by 4 low cycles; `motor` never high; `done` after the second gap.
- Vend with ch_in=01 in the same cycle → 8 `motor` cycles immediately followed by one 4-cycle coin pulse and 4-cycle gap; then `done`.
- Six consecutive vend events while the sequencer is busy → first pops immediately, next four queue, `full`=1, sixth is dropped and `overflow`=1. Exactly 5 `motor` bursts follow, and `overflow` stays 1.
- Assert R during the second coin pulse of a ch=10 event with 2 entries queued → next cycle all outputs 0, queue empty, `overflow` 0; no further pulses.
